ifetch_master: RTL and testbench

// - Instruction-fetch initiator for the DLX: drives the requester side of the read-only memory interface.
// - Holds the fetch PC and issues word reads, waits for DATA_READY, and buffers returned words in a prefetch FIFO.
// - Presents instructions to the decode stage with a valid/ready handshake.
// - Accepts branch/jump redirects from the pipeline.

---
 rtl/ifetch_master.sv | 176 +++++++++++++++++
 tb/tb_ifetch_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_master.sv
// Instruction-fetch initiator: word reads from a read-only memory into a prefetch FIFO,
// valid/ready handoff to decode, redirect flush. Optional IFETCH_TIMEOUT_EN adds a fetch watchdog.
module ifetch_master #(
  parameter int unsigned             WORD_SIZE      = 32,
  parameter int unsigned             ADDRESS_SIZE   = 16,
  parameter int unsigned             FIFO_DEPTH     = 4,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC       = '0,
  parameter int unsigned             TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mem_enable,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  input  logic [WORD_SIZE-1:0]    mem_data,
  input  logic                    mem_data_ready,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_SIZE-1:0] redirect_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [WORD_SIZE-1:0]    instr,
  output logic [ADDRESS_SIZE-1:0] instr_pc,
  output logic                    fetch_error
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StGap, StIdle, StFetch, StHalt} state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [WORD_SIZE-1:0]    data_q [FIFO_DEPTH];
  logic [ADDRESS_SIZE-1:0] addr_q [FIFO_DEPTH];

  logic full;
  logic push;
  logic pop;
  logic tmo_expire;

  assign full        = (count_q == CntW'(FIFO_DEPTH));
  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = addr_q[rd_ptr_q];
  assign mem_address = pc_q;

  // A redirect discards both the in-flight response and any pop in the same cycle.
  assign push = (state_q == StFetch) && mem_data_ready && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

`ifdef IFETCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;

  assign tmo_expire  = (state_q == StFetch) && !mem_data_ready &&
                       (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign fetch_error = err_q;

  always_comb begin
    tmo_d = '0;
    err_d = err_q;
    if (state_q == StFetch && !mem_data_ready && !tmo_expire) begin
      tmo_d = tmo_q + TmoW'(1);
    end
    if (tmo_expire) begin
      err_d = 1'b1;
    end
    if (redirect_valid) begin
      tmo_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo_expire  = 1'b0;
  assign fetch_error = 1'b0;
`endif

  // Request FSM
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_enable = 1'b0;
    unique case (state_q)
      StGap: begin
        state_d = full ? StIdle : StFetch;
      end
      StIdle: begin
        if (!full) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        mem_enable = 1'b1;
        if (mem_data_ready) begin
          pc_d    = pc_q + ADDRESS_SIZE'(4);
          state_d = StGap;
        end else if (tmo_expire) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StGap;
      end
    endcase
    if (redirect_valid) begin
      state_d = StGap;
      pc_d    = redirect_pc & ~ADDRESS_SIZE'(3);
    end
  end

  // Prefetch FIFO pointers
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StGap;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        data_q[wr_ptr_q] <= mem_data;
        addr_q[wr_ptr_q] <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_master.sv
// Directed bench for ifetch_master: bench-side ROM responder, scoreboard queue of expected
// {pc, word} pairs, and immediate-assertion checks at each step.
module tb_ifetch_master;

  logic        clk;
  logic        rst;
  logic        mem_enable;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_data_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        fetch_error;

  int          vectors;
  int          miscompares;
  logic [47:0] exp_q[$];
  logic [15:0] exp_pc;
  bit          rom_on;

  ifetch_master dut (
    .clk            (clk),
    .rst            (rst),
    .mem_enable     (mem_enable),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .mem_data_ready (mem_data_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_error    (fetch_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: rom = 32'h1111_1111;
      16'h0004: rom = 32'h2222_2222;
      16'h0008: rom = 32'h3333_3333;
      default:  rom = {16'hA500, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Zero-wait responder: answers in the same cycle the request is seen.
  task automatic respond();
    if (rom_on && mem_enable && !rst) begin
      mem_data_ready = 1'b1;
      mem_data       = rom(mem_address);
    end else begin
      mem_data_ready = 1'b0;
      mem_data       = 32'hDEAD_BEEF;
    end
  endtask

  // Pre-edge scoreboard bookkeeping, one clock, then the responder reacts.
  task automatic tick();
    logic [47:0] head;
    chk("instr_valid_vs_model", {63'd0, instr_valid}, {63'd0, exp_q.size() != 0});
    if (mem_enable && !rst) chk("mem_address", {48'd0, mem_address}, {48'd0, exp_pc});
    if (rst) begin
      exp_q.delete();
      exp_pc = 16'h0000;
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_pc = redirect_pc & 16'hFFFC;
    end else begin
      if (instr_valid && instr_ready && exp_q.size() != 0) begin
        head = exp_q.pop_front();
        chk("instr_head", {16'd0, instr_pc, instr}, {16'd0, head});
      end
      if (mem_enable && mem_data_ready) begin
        exp_q.push_back({exp_pc, mem_data});
        exp_pc = exp_pc + 16'h0004;
      end
    end
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 12 && !mem_enable; i++) tick();
    chk("wait_fetch", {63'd0, mem_enable}, 64'd1);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rom_on         = 1'b0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    instr_ready    = 1'b0;
    mem_data_ready = 1'b0;
    mem_data       = 32'hDEAD_BEEF;
    exp_pc         = 16'h0000;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_mem_enable", {63'd0, mem_enable}, 64'd0);
    chk("rst_mem_address", {48'd0, mem_address}, 64'h0);
    chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'h0);
    chk("rst_instr_pc", {48'd0, instr_pc}, 64'h0);
    chk("rst_fetch_error", {63'd0, fetch_error}, 64'd0);

    // Release: GAP then FETCH at 0, address held while no response
    rst = 1'b0;
    tick();
    chk("first_fetch_enable", {63'd0, mem_enable}, 64'd1);
    chk("first_fetch_address", {48'd0, mem_address}, 64'h0);
    repeat (2) tick();
    chk("fetch_hold_enable", {63'd0, mem_enable}, 64'd1);

    // Streaming with decode always ready
    rom_on      = 1'b1;
    instr_ready = 1'b1;
    respond();
    tick();
    chk("stream_w0", {32'd0, instr}, 64'h1111_1111);
    chk("stream_pc0", {48'd0, instr_pc}, 64'h0);
    chk("stream_gap", {63'd0, mem_enable}, 64'd0);
    tick();
    chk("stream_req1_enable", {63'd0, mem_enable}, 64'd1);
    chk("stream_req1_address", {48'd0, mem_address}, 64'h4);
    chk("stream_popped", {63'd0, instr_valid}, 64'd0);
    tick();
    chk("stream_w1", {32'd0, instr}, 64'h2222_2222);
    chk("stream_pc1", {48'd0, instr_pc}, 64'h4);
    repeat (2) tick();
    chk("stream_w2", {32'd0, instr}, 64'h3333_3333);
    chk("stream_pc2", {48'd0, instr_pc}, 64'h8);
    repeat (6) tick();

    // Back-pressure: restart at 0, fill the FIFO, then drain
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    chk("bp_flush_valid", {63'd0, instr_valid}, 64'd0);
    chk("bp_gap", {63'd0, mem_enable}, 64'd0);
    tick();
    chk("bp_restart_address", {48'd0, mem_address}, 64'h0);
    repeat (10) tick();
    chk("bp_full_idle", {63'd0, mem_enable}, 64'd0);
    chk("bp_head", {32'd0, instr}, 64'h1111_1111);
    repeat (3) tick();
    chk("bp_still_idle", {63'd0, mem_enable}, 64'd0);
    chk("bp_head_held", {32'd0, instr}, 64'h1111_1111);
    instr_ready = 1'b1;
    tick();
    chk("bp_pop1_pc", {48'd0, instr_pc}, 64'h4);
    tick();
    chk("bp_pop2_pc", {48'd0, instr_pc}, 64'h8);
    repeat (12) tick();

    // Redirect while a response is on the bus
    instr_ready = 1'b0;
    wait_fetch();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0102;
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush_valid", {63'd0, instr_valid}, 64'd0);
    chk("redir_gap", {63'd0, mem_enable}, 64'd0);
    tick();
    chk("redir_enable", {63'd0, mem_enable}, 64'd1);
    chk("redir_address", {48'd0, mem_address}, 64'h0100);
    tick();
    chk("redir_first_pc", {48'd0, instr_pc}, 64'h0100);
    chk("redir_first_word", {32'd0, instr}, {32'd0, 32'hA500_0100});

    // Redirect and pop together on a full FIFO; then pc wrap
    repeat (12) tick();
    chk("full_idle", {63'd0, mem_enable}, 64'd0);
    chk("full_valid", {63'd0, instr_valid}, 64'd1);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFC;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    chk("flush_wins", {63'd0, instr_valid}, 64'd0);
    tick();
    chk("wrap_req_address", {48'd0, mem_address}, 64'hFFFC);
    tick();
    chk("wrap_word_pc", {48'd0, instr_pc}, 64'hFFFC);
    tick();
    chk("wrap_next_enable", {63'd0, mem_enable}, 64'd1);
    chk("wrap_next_address", {48'd0, mem_address}, 64'h0000);

    // Unanswered fetch
    rom_on         = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("stall_enable", {63'd0, mem_enable}, 64'd1);
    repeat (15) tick();
    chk("stall_no_error_yet", {63'd0, fetch_error}, 64'd0);
    tick();
`ifdef IFETCH_TIMEOUT_EN
    chk("timeout_error", {63'd0, fetch_error}, 64'd1);
    chk("timeout_halt", {63'd0, mem_enable}, 64'd0);
`else
    chk("no_timeout_error", {63'd0, fetch_error}, 64'd0);
    chk("no_timeout_waiting", {63'd0, mem_enable}, 64'd1);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0300;
    tick();
    redirect_valid = 1'b0;
    chk("redirect_clears_error", {63'd0, fetch_error}, 64'd0);

    // Reset in the middle of a request
    rom_on = 1'b1;
    respond();
    wait_fetch();
    rst = 1'b1;
    tick();
    chk("midrst_enable", {63'd0, mem_enable}, 64'd0);
    chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
    chk("midrst_address", {48'd0, mem_address}, 64'h0);
    rst = 1'b0;
    tick();
    chk("midrst_refetch", {63'd0, mem_enable}, 64'd1);
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
